psram_qspi_slave: RTL
=====================

// Module: psram_qspi_slave
// PURPOSE
//  Synthesizable QSPI PSRAM device front-end, downstream of the APB PSRAM controller's qspi_sck/qspi_ce_n/qspi_dio pins.
//  Oversamples the QSPI bus in the system clock domain and decodes quad read (0xEB) and quad write (0x38).
//  Converts each transfer into byte accesses on a synchronous single-port SRAM interface.
//  Lets the SoC run the PSRAM path on FPGA without a behavioural chip model.
// PARAMETERS
//  ADDR_W       22  memory byte-address width; low ADDR_W bits of 24-bit QSPI address used
//  DUMMY_CYC    6   sck cycles between last address nibble and first read nibble (0xEB only)
//  SYNC_STAGES  2   synchronizer depth for sck, ce_n, dio inputs
// PORTS
//  clk_i       in   1       system clock; must run >= 8x qspi_sck frequency
//  rst_i       in   1       asynchronous active-high reset
//  qspi_sck    in   1       QSPI clock from controller
//  qspi_ce_n   in   1       chip enable, active low
//  dio_i       in   4       QSPI data in from pad
//  dio_o       out  4       QSPI data out to pad
//  dio_oe      out  4       per-bit pad output enable (top-level tristate: oe ? o : z)
//  mem_req     out  1       one-cycle access strobe
//  mem_we      out  1       1 = write, 0 = read; valid with mem_req
//  mem_addr    out  ADDR_W  byte address; valid with mem_req
//  mem_wdata   out  8       write byte; valid with mem_req & mem_we
//  mem_rdata   in   8       read byte, valid exactly 1 clk_i after read mem_req
// BEHAVIOUR
//  Reset: dio_o=0, dio_oe=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, FSM=IDLE. Reset mid-transfer aborts it; no pending mem_req issued.
//  Inputs pass SYNC_STAGES flops; rise/fall pulses come from synced sck. Input sampling on rise, output update on fall (SPI mode 0).
//  Pad-to-dio_o latency: SYNC_STAGES+1 clk_i after sck fall.
//  Synced ce_n high in any state -> IDLE next cycle; dio_oe=0. Unfinished byte discarded; completed writes are kept.
//  FSM:
//   IDLE   ce_n low -> CMD, bit count cleared.
//   CMD    8 rises sampling dio_i[0], MSB first. 0xEB->ADDR(rd); 0x38->ADDR(wr); others->IGNORE.
//   ADDR   6 rises of 4 bits each, MSB nibble first, forming addr[23:0]. Rd: at 6th rise issue read mem_req @addr -> DUMMY. Wr: -> WDATA.
//   DUMMY  DUMMY_CYC rises, dio_oe=0. On the fall after the last rise: dio_oe=4'hF, drive rdata[7:4] -> RDATA.
//   RDATA  Alternate falls drive low then high nibble from a latched byte buffer.
//          At the fall driving low nibble: issue read @addr+1, latch result 1 clk later. Next high-nibble fall uses new byte.
//   WDATA  Rise 1 captures high nibble, rise 2 low nibble. Then mem_req/mem_we=1 @addr for 1 cycle; addr++.
//   IGNORE No outputs until ce_n high.
//  Address increments modulo 2^ADDR_W (wraps to 0); no page boundary.
//  Simultaneous ce_n rise and sck edge in one synced cycle: ce_n wins, edge ignored.
//  At most one mem_req per 4 clk_i; no back-pressure on memory port.
// CONFIGURATION
//  PSRAM_QPI_EN defined: also decodes 0x35 (enter QPI) and 0xF5 (exit QPI); qpi flag resets to 0.
//   In QPI mode CMD takes 2 rises of 4 bits; 0x35/0xF5 take effect at ce_n rise.
//   Effect after 0x35: 0xEB/0x38 behave the same after CMD. Effect after 0xF5: return to 8-rise serial CMD.
//  PSRAM_QPI_EN undefined: 0x35/0xF5 -> IGNORE; CMD always serial.
// STRUCTURE
//  psram_pkg: opcode localparams (OP_QREAD=8'hEB, OP_QWRITE=8'h38, OP_QPI_EN=8'h35, OP_QPI_EX=8'hF5), state enum, bit counts (CMD 8, ADDR 6).
//  Sub-module psram_pin_sync: SYNC_STAGES synchronizer for {sck,ce_n,dio_i}, plus sck_rise/sck_fall pulses.
// TESTING
//  Quad read: mem[0x10]=0x12, mem[0x11]=0x34; send 0xEB, addr 0x000010, 6 dummy.
//   -> dio_o nibbles 1,2,3,4 on successive falls; dio_oe=F only after dummy.
//  Quad write: 0x38, addr 0x000020, data 0xAB,0xCD.
//   -> mem writes (0x20,0xAB), (0x21,0xCD); exactly 2 mem_req.
//  Abort: 0x38, addr 0x40, one nibble then ce_n high -> no mem_req. Next 0xEB read @0x40 returns prior content.
//  Wrap: read addr 0x3FFFFF, 2 bytes (ADDR_W=22) -> mem_addr 0x3FFFFF then 0x000000.
//  Unknown opcode 0x9F with 16 further sck -> dio_oe=0, mem_req=0 throughout.
//  Reset: assert rst_i mid-RDATA -> dio_oe=0 same cycle. Next transaction decodes normally.
//  PSRAM_QPI_EN: 0x35 serial, then 0xEB in 2 quad cycles, read @0x10 -> 1,2,3,4. Without macro, same stream -> IGNORE.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared opcodes, FSM state codes and frame lengths for the QSPI PSRAM slave.
package psram_pkg;
  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_QWRITE = 8'h38;
  localparam logic [7:0] OP_QPI_EN = 8'h35;
  localparam logic [7:0] OP_QPI_EX = 8'hF5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_WDATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  localparam logic [7:0] CMD_BITS  = 8'd8;
  localparam logic [7:0] ADDR_NIBS = 8'd6;
endpackage

// File: rtl/psram_pin_sync.sv
// Synchronizes {sck, ce_n, dio} into clk_i and derives one-cycle sck edge pulses.
module psram_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       qspi_sck,
  input  logic       qspi_ce_n,
  input  logic [3:0] dio_i,
  output logic       ce_n_s,
  output logic [3:0] dio_s,
  output logic       sck_rise,
  output logic       sck_fall
);
  // ce_n resets deasserted so the FSM stays idle until the bus really selects us
  localparam logic [5:0] RST_VAL = 6'b01_0000;

  logic [SYNC_STAGES-1:0][5:0] pipe;
  logic sck_s, sck_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe  <= {SYNC_STAGES{RST_VAL}};
      sck_q <= 1'b0;
    end else begin
      pipe[0] <= {qspi_sck, qspi_ce_n, dio_i};
      for (int i = 1; i < SYNC_STAGES; i++) pipe[i] <= pipe[i-1];
      sck_q <= sck_s;
    end
  end

  assign {sck_s, ce_n_s, dio_s} = pipe[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
endmodule

// File: rtl/psram_qspi_slave.sv
// QSPI PSRAM front-end: decodes 0xEB quad read / 0x38 quad write into byte SRAM accesses.
// Define PSRAM_QPI_EN to add 0x35/0xF5 QPI enter/exit with 2-rise quad command phase.
module psram_qspi_slave
  import psram_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int DUMMY_CYC   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              qspi_sck,
  input  logic              qspi_ce_n,
  input  logic [3:0]        dio_i,
  output logic [3:0]        dio_o,
  output logic [3:0]        dio_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  localparam logic [7:0] DUMMY_N = 8'(DUMMY_CYC);

  logic              ce_n_s, sck_rise, sck_fall;
  logic [3:0]        dio_s;
  logic [2:0]        state;
  logic [7:0]        cnt;
  logic [19:0]       sreg;
  logic [ADDR_W-1:0] addr, addr_inc;
  logic              is_rd, drive_hi;
  logic [7:0]        byte_buf, cmd_nxt;
  logic [3:0]        wr_hi;
  logic [1:0]        vld_pipe;
  logic              cmd_last;
  logic [23:0]       addr_full;
  logic              unused_hi;
  logic              qpi;

  psram_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i), .rst_i(rst_i), .qspi_sck(qspi_sck), .qspi_ce_n(qspi_ce_n),
    .dio_i(dio_i), .ce_n_s(ce_n_s), .dio_s(dio_s), .sck_rise(sck_rise), .sck_fall(sck_fall)
  );

`ifdef PSRAM_QPI_EN
  logic qpi_nxt;
`else
  assign qpi = 1'b0;
`endif

  always_comb begin
    cmd_nxt   = qpi ? {sreg[3:0], dio_s} : {sreg[6:0], dio_s[0]};
    cmd_last  = qpi ? (cnt == 8'd1) : (cnt == CMD_BITS - 8'd1);
    addr_full = {sreg, dio_s};
  end
  assign addr_inc  = addr + ADDR_W'(1);
  assign unused_hi = ^(addr_full >> ADDR_W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sreg      <= '0;
      addr      <= '0;
      is_rd     <= 1'b0;
      drive_hi  <= 1'b0;
      byte_buf  <= '0;
      wr_hi     <= '0;
      vld_pipe  <= '0;
      dio_o     <= '0;
      dio_oe    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef PSRAM_QPI_EN
      qpi       <= 1'b0;
      qpi_nxt   <= 1'b0;
`endif
    end else begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      // read data lands one clk after the strobe is seen by the SRAM
      vld_pipe <= {vld_pipe[0], 1'b0};
      if (vld_pipe[1]) byte_buf <= mem_rdata;
      if (ce_n_s) begin
        state  <= ST_IDLE;
        dio_oe <= '0;
`ifdef PSRAM_QPI_EN
        qpi    <= qpi_nxt;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_CMD;
            cnt   <= '0;
          end
          ST_CMD: if (sck_rise) begin
            sreg <= qpi ? {sreg[15:0], dio_s} : {sreg[18:0], dio_s[0]};
            cnt  <= cnt + 8'd1;
            if (cmd_last) begin
              cnt   <= '0;
              state <= ST_IGNORE;
              if (cmd_nxt == OP_QREAD || cmd_nxt == OP_QWRITE) begin
                state <= ST_ADDR;
                is_rd <= (cmd_nxt == OP_QREAD);
              end
`ifdef PSRAM_QPI_EN
              if (cmd_nxt == OP_QPI_EN) qpi_nxt <= 1'b1;
              if (cmd_nxt == OP_QPI_EX) qpi_nxt <= 1'b0;
`endif
            end
          end
          ST_ADDR: if (sck_rise) begin
            sreg <= {sreg[15:0], dio_s};
            cnt  <= cnt + 8'd1;
            if (cnt == ADDR_NIBS - 8'd1) begin
              cnt  <= '0;
              addr <= addr_full[ADDR_W-1:0];
              if (is_rd) begin
                mem_req     <= 1'b1;
                mem_addr    <= addr_full[ADDR_W-1:0];
                vld_pipe[0] <= 1'b1;
                state       <= ST_DUMMY;
              end else begin
                state <= ST_WDATA;
              end
            end
          end
          ST_DUMMY: begin
            if (sck_rise) cnt <= cnt + 8'd1;
            if (sck_fall && cnt == DUMMY_N) begin
              dio_oe   <= 4'hF;
              dio_o    <= byte_buf[7:4];
              drive_hi <= 1'b0;
              state    <= ST_RDATA;
            end
          end
          ST_RDATA: if (sck_fall) begin
            drive_hi <= ~drive_hi;
            if (drive_hi) begin
              dio_o <= byte_buf[7:4];
            end else begin
              // prefetch next byte while the low nibble is on the wire
              dio_o       <= byte_buf[3:0];
              mem_req     <= 1'b1;
              mem_addr    <= addr_inc;
              addr        <= addr_inc;
              vld_pipe[0] <= 1'b1;
            end
          end
          ST_WDATA: if (sck_rise) begin
            if (!cnt[0]) begin
              wr_hi <= dio_s;
              cnt   <= 8'd1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= {wr_hi, dio_s};
              addr      <= addr_inc;
              cnt       <= '0;
            end
          end
          ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
